// File: rtl/alu_result_queue.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_queue
// Purpose  : In-order result FIFO behind the datapath ALU. Buffers results
//            and their {v,n,z} flags between two valid/ready handshakes and
//            maintains the architectural status flags and a sticky overflow
//            bit, both updated as entries retire.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_queue #(
  parameter int BW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BW-1:0]              in_result,
  input  logic [2:0]                 in_flags,
  input  logic                       in_flags_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BW-1:0]              out_result,
  output logic [2:0]                 out_flags,
  output logic [2:0]                 status_flags,
  output logic                       sticky_ovf,
  input  logic                       clr_sticky,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = BW + 4;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // Entry layout: {result, v, n, z, flags_en}
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic          head_en;
  logic          head_v;
  logic          retire_ovf;

  // Handshake qualifiers come only from registered occupancy, so out_ready
  // never reaches in_ready combinationally.
  assign in_ready   = (count != FULL_COUNT);
  assign out_valid  = (count != '0);
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;

  assign head       = mem[rptr];
  assign head_en    = head[0];
  assign head_v     = head[3];
  assign retire_ovf = pop & head_en & head_v;

  assign out_result = out_valid ? head[EW-1:4] : '0;
  assign out_flags  = out_valid ? head[3:1]    : 3'b000;

  // Storage write; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wptr] <= {in_result, in_flags, in_flags_en};
    end
  end

  // Pointers, occupancy and retire-side architectural state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      status_flags <= 3'b000;
      sticky_ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop && head_en) begin
        status_flags <= head[3:1];
      end

      // An overflow retiring this cycle outranks a clear request.
      if (retire_ovf) begin
        sticky_ovf <= 1'b1;
      end else if (clr_sticky) begin
        sticky_ovf <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
